// File: rtl/proc_param_pkg.sv
// Shared definitions for processador_param: opcodes, FSM encoding and IR field offsets.
package proc_param_pkg;

  localparam logic [3:0] OP_MV   = 4'd0;
  localparam logic [3:0] OP_MVI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_LD   = 4'd4;
  localparam logic [3:0] OP_ST   = 4'd5;
  localparam logic [3:0] OP_MVNZ = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_SLT  = 4'd10;
  localparam logic [3:0] OP_SHL  = 4'd11;
  localparam logic [3:0] OP_SHR  = 4'd12;
  localparam logic [3:0] OP_HALT = 4'd13;
  localparam logic [3:0] OP_MUL  = 4'd14;
  localparam logic [3:0] OP_NOP  = 4'd15;

  typedef enum logic [2:0] {
    S_FETCH,
    S_FWAIT,
    S_EX1,
    S_EX2,
    S_EX3,
    S_MWAIT,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    WB_RY,
    WB_G,
    WB_DIN
  } wb_sel_e;

  // IR layout: {op[3:0], rX, rY} in the low bits of the word
  function automatic int unsigned ir_w(input int unsigned reg_w);
    return 2 * reg_w + 4;
  endfunction

  function automatic int unsigned op_lsb(input int unsigned reg_w);
    return 2 * reg_w;
  endfunction

  function automatic int unsigned rx_lsb(input int unsigned reg_w);
    return reg_w;
  endfunction

endpackage

// File: rtl/ula_param.sv
// Combinational ALU for processador_param; opcode 14 is mul only when PROC_MULT_EN is defined.
module ula_param
  import proc_param_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  output logic [DATA_W-1:0] result_c,
  output logic              zero_c
);

  logic [3:0] sh_amt;
  logic       sh_over;

  assign sh_amt  = in2[3:0];
  assign sh_over = (32'(sh_amt) >= DATA_W);

  always_comb begin
    result_c = '0;
    case (op)
      OP_ADD:  result_c = in1 + in2;
      OP_SUB:  result_c = in1 - in2;
      OP_AND:  result_c = in1 & in2;
      OP_OR:   result_c = in1 | in2;
      OP_XOR:  result_c = in1 ^ in2;
      OP_SLT:  result_c = DATA_W'($signed(in1) < $signed(in2));
      OP_SHL:  result_c = sh_over ? '0 : (in1 << sh_amt);
      OP_SHR:  result_c = sh_over ? '0 : (in1 >> sh_amt);
`ifdef PROC_MULT_EN
      OP_MUL:  result_c = DATA_W'(in1 * in2);
`endif
      default: result_c = '0;
    endcase
  end

  assign zero_c = (result_c == '0);

endmodule

// File: rtl/processador_param.sv
// Parametrised multicycle core with wait-state memory handshake, halt and debug read port.
// Define PROC_MULT_EN to make opcode 14 a mul; without it opcode 14 retires as a nop.
module processador_param
  import proc_param_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              run,
  input  logic [DATA_W-1:0] DIN,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] ADDR_out,
  output logic [DATA_W-1:0] DOUT_out,
  output logic              W_out,
  output logic              done,
  output logic              halted,
  output logic [DATA_W-1:0] pc_out,
  input  logic [REG_W-1:0]  dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned      NREGS  = 2 ** REG_W;
  localparam int unsigned      IR_W   = ir_w(REG_W);
  localparam int unsigned      OP_LSB = op_lsb(REG_W);
  localparam int unsigned      RX_LSB = rx_lsb(REG_W);
  localparam logic [REG_W-1:0] PC_SEL = REG_W'(NREGS - 1);

  logic [DATA_W-1:0] regs [NREGS];
  logic [IR_W-1:0]   ir;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] g_reg;
  logic              z_flag;
  state_e            state;
  state_e            state_nxt;

  logic [3:0]        op;
  logic [REG_W-1:0]  rx;
  logic [REG_W-1:0]  ry;
  logic [DATA_W-1:0] rx_val;
  logic [DATA_W-1:0] ry_val;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;
  logic [DATA_W-1:0] wb_data;

  logic    pc_inc, addr_pc, addr_ry, dout_ld, w_set, w_clr;
  logic    ir_ld, a_ld, g_ld, rf_we, retire;
  wb_sel_e wb_sel;

  assign op       = ir[OP_LSB +: 4];
  assign rx       = ir[RX_LSB +: REG_W];
  assign ry       = ir[REG_W-1:0];
  assign rx_val   = regs[rx];
  assign ry_val   = regs[ry];
  assign pc_out   = regs[PC_SEL];
  assign dbg_data = regs[dbg_sel];

  ula_param #(.DATA_W(DATA_W)) u_ula (
    .op       (op),
    .in1      (a_reg),
    .in2      (ry_val),
    .result_c (alu_res),
    .zero_c   (alu_zero)
  );

  always_comb begin
    wb_data = ry_val;
    case (wb_sel)
      WB_G:    wb_data = g_reg;
      WB_DIN:  wb_data = DIN;
      default: wb_data = ry_val;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= S_FETCH;
    end else if (run) begin
      state <= state_nxt;
    end
  end

  // Next state plus datapath strobes for the current state
  always_comb begin
    state_nxt = state;
    pc_inc    = 1'b0;
    addr_pc   = 1'b0;
    addr_ry   = 1'b0;
    dout_ld   = 1'b0;
    w_set     = 1'b0;
    w_clr     = 1'b0;
    ir_ld     = 1'b0;
    a_ld      = 1'b0;
    g_ld      = 1'b0;
    rf_we     = 1'b0;
    retire    = 1'b0;
    wb_sel    = WB_RY;
    case (state)
      S_FETCH: begin
        addr_pc   = 1'b1;
        pc_inc    = 1'b1;
        state_nxt = S_FWAIT;
      end
      S_FWAIT: begin
        if (mem_ready) begin
          ir_ld     = 1'b1;
          state_nxt = S_EX1;
        end
      end
      S_EX1: begin
        case (op)
          OP_MV: begin
            rf_we  = 1'b1;
            retire = 1'b1;
          end
          OP_MVI: begin
            addr_pc   = 1'b1;
            pc_inc    = 1'b1;
            state_nxt = S_MWAIT;
          end
          OP_LD: begin
            addr_ry   = 1'b1;
            state_nxt = S_MWAIT;
          end
          OP_ST: begin
            addr_ry   = 1'b1;
            dout_ld   = 1'b1;
            w_set     = 1'b1;
            state_nxt = S_MWAIT;
          end
          OP_MVNZ: begin
            rf_we  = !z_flag;
            retire = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SHL, OP_SHR: begin
            a_ld      = 1'b1;
            state_nxt = S_EX2;
          end
`ifdef PROC_MULT_EN
          OP_MUL: begin
            a_ld      = 1'b1;
            state_nxt = S_EX2;
          end
          OP_NOP:  retire = 1'b1;
`else
          OP_MUL, OP_NOP: retire = 1'b1;
`endif
          OP_HALT: state_nxt = S_HALT;
          default: retire = 1'b1;
        endcase
      end
      S_EX2: begin
        g_ld      = 1'b1;
        state_nxt = S_EX3;
      end
      S_EX3: begin
        rf_we  = 1'b1;
        wb_sel = WB_G;
        retire = 1'b1;
      end
      S_MWAIT: begin
        if (mem_ready) begin
          if (op == OP_ST) begin
            w_clr = 1'b1;
          end else begin
            rf_we  = 1'b1;
            wb_sel = WB_DIN;
          end
          retire = 1'b1;
        end
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
    if (retire) begin
      state_nxt = S_FETCH;
    end
  end

  // Datapath; the rX write comes last so a write to the PC overrides its increment
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[REG_W'(i)] <= '0;
      end
      ir       <= '0;
      a_reg    <= '0;
      g_reg    <= '0;
      z_flag   <= 1'b0;
      ADDR_out <= '0;
      DOUT_out <= '0;
      W_out    <= 1'b0;
      done     <= 1'b0;
      halted   <= 1'b0;
    end else if (run) begin
      done   <= retire;
      halted <= (state_nxt == S_HALT);
      if (pc_inc)  regs[PC_SEL] <= regs[PC_SEL] + DATA_W'(1);
      if (addr_pc) ADDR_out <= regs[PC_SEL];
      if (addr_ry) ADDR_out <= ry_val;
      if (dout_ld) DOUT_out <= rx_val;
      if (w_set)   W_out <= 1'b1;
      if (w_clr)   W_out <= 1'b0;
      if (ir_ld)   ir <= DIN[IR_W-1:0];
      if (a_ld)    a_reg <= rx_val;
      if (g_ld) begin
        g_reg  <= alu_res;
        z_flag <= alu_zero;
      end
      if (rf_we)   regs[rx] <= wb_data;
    end
  end

endmodule

// File: doc/processador_param.md
Name: processador_param

Overview:
- Parametrised multicycle processor core; successor of the fixed 16-bit, 8-register core.
- Parametrised data width and register count, wider opcode set, zero flag and memory wait-state handshake (mem_ready).
- Adds halt and a debug register read port; sits between instruction/data memory and the board I/O wrapper.

Parameters:
- DATA_W, 16, data and instruction word width; must be >= 2*REG_W+4.
- REG_W, 3, register index width; NREGS = 2**REG_W; register NREGS-1 is the PC.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  synchronous active-low reset.
- run  in  1  high = advance; low = freeze all state.
- DIN  in  DATA_W  memory read data; valid in any cycle where mem_ready=1.
- mem_ready  in  1  memory completes the access in this cycle.
- ADDR_out  out  DATA_W  memory address register.
- DOUT_out  out  DATA_W  memory write data register.
- W_out  out  1  memory write enable (registered).
- done  out  1  one-cycle pulse per retired instruction.
- halted  out  1  core is in HALT.
- pc_out  out  DATA_W  current PC (register NREGS-1).
- dbg_sel  in  REG_W  debug register select.
- dbg_data  out  DATA_W  combinational read of register dbg_sel.

Behaviour:
- Reset (resetn=0 at edge): all registers, PC, A, G, IR, ADDR, DOUT = 0; W_out=0; done=0; Z=0; state FETCH. Reset has priority over run and acts mid-instruction, including during wait states.
- IR fields: op = IR[2*REG_W+3:2*REG_W]; rX = IR[2*REG_W-1:REG_W]; rY = IR[REG_W-1:0].
- Opcodes: 0 mv rX<-rY; 1 mvi rX<-next word; 2 add; 3 sub; 4 ld rX<-M[rY]; 5 st M[rY]<-rX; 6 mvnz (rX<-rY if Z=0); 7 and; 8 or; 9 xor; 10 slt (signed, result 1/0); 11 shl by rY[3:0]; 12 shr logical by rY[3:0]; 13 halt; 14 reserved; 15 nop.
- States and transitions:
  - FETCH: ADDR<-PC; PC<-PC+1; go to FWAIT.
  - FWAIT: hold until mem_ready=1, then IR<-DIN; go to EX1.
  - EX1:
    - mv: write rX; retire.
    - ALU ops: A<-rX; go to EX2.
    - mvi: ADDR<-PC; PC<-PC+1; go to MWAIT.
    - ld: ADDR<-rY; go to MWAIT.
    - st: ADDR<-rY; DOUT<-rX; W<-1; go to MWAIT.
    - mvnz: conditional write; retire.
    - nop/reserved: retire.
    - halt: go to HALT.
  - EX2: G<-A op rY; Z<-(result==0); go to EX3.
  - EX3: rX<-G; retire.
  - MWAIT: hold until mem_ready=1, then:
    - mvi/ld: rX<-DIN.
    - st: W<-0.
    - Retire.
  - HALT: absorbing; halted=1; exits only by reset.
- Retire: done=1 in the following cycle, for exactly one cycle; next state FETCH.
- Latency with mem_ready tied high: mv/mvnz/nop 3 cycles; mvi/ld/st 4; ALU 5.
- Each extra mem_ready-low cycle adds one cycle. W_out stays 1 for the whole st wait.
- Arithmetic is modulo 2**DATA_W with no carry out. Shift amounts >= DATA_W give 0. Z changes only in EX2.
- PC as rX: the write overrides the increment, giving a jump. PC as rY reads the already-incremented value.
- run=0: no register, flag, state or done change. Outputs hold. mem_ready is ignored while frozen.
- Writes occur only at clock edges with run=1.

Optional Feature:
- Macro PROC_MULT_EN.
- Defined: opcode 14 = mul, rX <- low DATA_W bits of rX*rY through EX2/EX3; updates Z.
- Undefined: opcode 14 behaves as nop.

Decomposition:
- Package proc_param_pkg: opcode localparams, FSM state encoding, IR field offset functions.
- One sub-module ula_param: combinational ALU (op, in1, in2 -> result, zero), parametrised by DATA_W.
- Register file stays inline.

Test Plan:
- Reset then run, mem_ready=1:
  - Inputs: IR mvi R0 with word 0x0005, then mv R1,R0.
  - Expected: R1=0x0005; pc_out=3; done pulses 2 times; 7 cycles total.
- Overflow and zero flag:
  - Inputs: R0=0xFFFF, R1=0x0001; add R0,R1; then mvnz R2,R1.
  - Expected: R0=0x0000; Z=1; R2 unchanged.
- Store/load with wait states:
  - Inputs: st R0,R1 with mem_ready low for 3 cycles, then ld R2,R1.
  - Expected: W_out=1 for exactly 4 cycles; R2 equals stored value.
- Freeze mid-instruction:
  - Inputs: run=0 for 5 cycles during EX2 of sub.
  - Expected: all outputs unchanged; on resume, result correct and done after 2 more cycles.
- Halt and reset mid-wait:
  - Inputs: halt; then resetn=0 during an FWAIT.
  - Expected: halted=1 with no further done; after reset pc_out=0, W_out=0, halted=0.
- With PROC_MULT_EN:
  - Inputs: R0=0x0102, R1=0x0100, opcode 14.
  - Expected: R0=0x0200.
  - Without the macro: R0 unchanged, done pulses once.
